fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and hazard controller for the integer pipeline, replacing the fixed two-stage, three-operand forwarding decode. It keeps its own shadow pipeline of destination tags from EXE down to the last bypass stage, and generates per-operand bypass selects for the instruction in EXE. It also detects load-use hazards for any load-return stage, inserts bubbles, honours memory back-pressure and branch flush, and counts stall cycles.

## Interface
Parameters:
- ADDR_W, 4: register-file address width.
- NUM_SRC, 3: source operands per instruction (val1, val2, store value).
- DEPTH, 3: shadow slots; slot 0 = EXE, slot 1 = MEM, slot DEPTH-1 = last bypassable stage.
- LOAD_STAGE, 2: slot index at which load data is first bypassable (1 ≤ LOAD_STAGE < DEPTH).
- ZERO_REG_EN, 0: if 1, register 0 never matches.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  valid instruction in ID.
- id_src  in  NUM_SRC×ADDR_W  ID source register numbers.
- id_src_used  in  NUM_SRC  per-source "operand read" flags.
- id_dest  in  ADDR_W  ID destination.
- id_wb_en  in  1  ID instruction writes back.
- id_is_load  in  1  ID instruction is a load.
- mem_busy  in  1  memory stall; freezes whole pipeline.
- flush  in  1  kill ID instruction (taken branch).
- stall  out  1  hold PC and IF/ID register.
- fwd_sel  out  NUM_SRC×FWD_SEL_W  per-EXE-source select: 0 = register file, k = slot k.
- stall_cnt  out  32  saturating count of cycles with stall=1.

## Operation
- Slot fields: valid, wb_en, dest, is_load. Slot 0 also holds src[NUM_SRC] and src_used.
- Advance when mem_busy=0: slot[i] ← slot[i-1] for i ≥ 1. Slot 0 ← ID fields if id_valid & ~flush & ~load_use, else a bubble (valid=0, wb_en=0).
- Freeze when mem_busy=1: every slot holds. stall=1. flush is ignored; the upstream stage holds flush until a cycle with mem_busy=0.
- fwd_sel[s] is combinational from registered state. It is the smallest k in 1..DEPTH-1 where slot[k].valid & wb_en & dest==slot0.src[s] & slot0.src_used[s]. If there is no match, or ZERO_REG_EN and src==0, it is 0. If slot 0 is invalid, it is 0.
- Load-use: for each used id_src, take the nearest matching writer j in 0..DEPTH-2 (slots ahead of ID). If that writer is a load and j+1 < LOAD_STAGE, load_use=1. A nearer non-load writer masks an older load.
- stall = mem_busy | (load_use & id_valid & ~flush). Flush overrides load_use.
- stall_cnt increments when stall=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset: all slots invalid with zero fields, stall_cnt=0. fwd_sel=0 the cycle after reset. stall=mem_busy while rst is held.
- rst asserted mid-stall: next cycle all state is cleared, and any pending bubble or held instruction is dropped.
- fwd_sel and stall are combinational outputs with zero-cycle latency from registered state/inputs. Slot updates take effect one cycle after the edge.
- Load-use stall length is LOAD_STAGE-1-j cycles (defaults: 1 cycle for load in EXE). mem_busy cycles extend it without losing the pending hazard.
- Simultaneous flush & mem_busy: freeze wins. Flush is accepted on the first non-busy cycle.

## Structure
- Add to the shared defines package: FWD_SEL_W = $clog2(DEPTH), the slot struct typedef (valid, wb_en, is_load, dest), and the FWD_RF = 0 constant.
- One sub-module, fwd_match: a nearest-match priority encoder over slots. It is used NUM_SRC times for fwd_sel and reused for load-use lookup on the ID sources.

## Test plan
- ADD r3 → next SUB src1=r3 → fwd_sel[0]=1. One cycle later, for an instruction reading r3 two behind, fwd_sel=2. With r3 in both MEM and WB, sel=1.
- LDR r5 then ADD src2=r5 (LOAD_STAGE=2) → stall=1 for exactly 1 cycle with bubble in EXE, then fwd_sel[1]=2 and stall_cnt=1.
- LDR r5, ADD r5, SUB src=r5 → no stall; SUB gets fwd_sel=1 (non-load masks load).
- Load-use hazard with mem_busy=1 for 3 cycles → stall held 4 cycles, slots frozen, stall_cnt=4, then normal forwarding.
- flush with a pending load-use → stall=0, bubble enters EXE. flush with mem_busy → ignored until mem_busy drops.
- ZERO_REG_EN=1, writer to r0 → fwd_sel=0. rst mid-stall → all sel 0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
// Tags are stored at ADDR_MAX_W and zero-extended from the port width.
package fwd_hazard_unit_pkg;

   localparam int ADDR_MAX_W = 8;
   localparam int FWD_DEPTH  = 3;
   localparam int FWD_SEL_W  = $clog2(FWD_DEPTH);
   localparam int FWD_RF     = 0;

   typedef struct packed {
      logic                  valid;
      logic                  wb_en;
      logic                  is_load;
      logic [ADDR_MAX_W-1:0] dest;
   } slot_t;

   function automatic int sel_w(input int depth);
      return (depth < 3) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Nearest-match priority encoder over a window of shadow slots.
// Index 0 of the window is the youngest (closest) writer.
module fwd_match
   import fwd_hazard_unit_pkg::*;
#(
   parameter int N           = 2,
   parameter int IDX_W       = 1,
   parameter bit ZERO_REG_EN = 1'b0
) (
   input  slot_t [N-1:0]          slots,
   input  logic [ADDR_MAX_W-1:0]  src,
   input  logic                   used,
   output logic                   hit,
   output logic [IDX_W-1:0]       idx
);

   logic live;

   assign live = used & ~(ZERO_REG_EN & (src == '0));

   // Scan oldest to youngest so the nearest writer is the last to win.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (live && slots[k].valid && slots[k].wb_en
             && slots[k].dest == src) begin
            hit = 1'b1;
            idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard control for the integer pipe.
// Keeps a shadow pipeline of destination tags from EXE onward.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int NUM_SRC     = 3,
   parameter int DEPTH       = 3,
   parameter int LOAD_STAGE  = 2,
   parameter bit ZERO_REG_EN = 1'b0,
   localparam int SEL_W      = sel_w(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       id_valid,
   input  logic [NUM_SRC*ADDR_W-1:0]  id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic [ADDR_W-1:0]          id_dest,
   input  logic                       id_wb_en,
   input  logic                       id_is_load,
   input  logic                       mem_busy,
   input  logic                       flush,
   output logic                       stall,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic [31:0]                stall_cnt
);

   typedef logic [ADDR_MAX_W-1:0] reg_t;

   slot_t [DEPTH-1:0]   slot_q;
   reg_t [NUM_SRC-1:0]  src_q;
   logic [NUM_SRC-1:0]  used_q;
   reg_t [NUM_SRC-1:0]  id_reg;
   logic [NUM_SRC-1:0]  lu_src;
   logic                load_use;
   logic                accept;
   slot_t               id_slot;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      logic             f_hit;
      logic             l_hit;
      logic [SEL_W-1:0] f_idx;
      logic [SEL_W-1:0] l_idx;

      assign id_reg[s] = reg_t'(id_src[s*ADDR_W +: ADDR_W]);

      fwd_match #(
         .N(DEPTH - 1), .IDX_W(SEL_W), .ZERO_REG_EN(ZERO_REG_EN)
      ) u_fwd (
         .slots (slot_q[DEPTH-1:1]),
         .src   (src_q[s]),
         .used  (used_q[s]),
         .hit   (f_hit),
         .idx   (f_idx)
      );

      fwd_match #(
         .N(DEPTH - 1), .IDX_W(SEL_W), .ZERO_REG_EN(ZERO_REG_EN)
      ) u_lu (
         .slots (slot_q[DEPTH-2:0]),
         .src   (id_reg[s]),
         .used  (id_src_used[s]),
         .hit   (l_hit),
         .idx   (l_idx)
      );

      assign fwd_sel[s*SEL_W +: SEL_W] =
         (slot_q[0].valid && f_hit) ? f_idx + SEL_W'(1)
                                    : SEL_W'(FWD_RF);

      assign lu_src[s] = l_hit && slot_q[l_idx].is_load
                         && (int'(l_idx) + 1 < LOAD_STAGE);
   end

   assign load_use = |lu_src;
   assign accept   = id_valid & ~flush & ~load_use;
   assign stall    = mem_busy
                     | (~rst & load_use & id_valid & ~flush);

   // Build the EXE entry: the ID instruction or an all-zero bubble.
   always_comb begin
      id_slot = '0;
      if (accept) begin
         id_slot.valid   = 1'b1;
         id_slot.wb_en   = id_wb_en;
         id_slot.is_load = id_is_load;
         id_slot.dest    = reg_t'(id_dest);
      end
   end

   // Shadow tag pipeline: holds while memory is busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
         src_q  <= '0;
         used_q <= '0;
      end else if (!mem_busy) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            slot_q[i] <= slot_q[i-1];
         end
         slot_q[0] <= id_slot;
         src_q     <= accept ? id_reg : '0;
         used_q    <= accept ? id_src_used : '0;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule
